// File: rtl/reg_writeback_queue.sv
`timescale 1ns/1ps
// reg_writeback_queue
//   In-order writeback buffer in front of the register file's single write
//   port. It takes up to two writes per cycle (primary, then secondary) and
//   drains one per cycle. It also flags read-after-write hazards against
//   queued entries.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   wr1_valid/dst/data    primary write request (enqueued first)
//   wr2_valid/dst/data    secondary write request (enqueued second)
//   accept                at least two free slots, from the registered count
//   rf_we/rf_dst/rf_data  register file write port (head of queue)
//   chk_src1/chk_src2     read addresses to compare against queued writes
//   hazard1/hazard2       an occupied entry targets chk_src1/chk_src2
//   count, empty          occupancy
//   overflow              sticky: a request arrived while accept was low
module reg_writeback_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr1_valid,
  input  logic [ADDR_W-1:0]          wr1_dst,
  input  logic [DATA_W-1:0]          wr1_data,
  input  logic                       wr2_valid,
  input  logic [ADDR_W-1:0]          wr2_dst,
  input  logic [DATA_W-1:0]          wr2_data,
  output logic                       accept,
  output logic                       rf_we,
  output logic [ADDR_W-1:0]          rf_dst,
  output logic [DATA_W-1:0]          rf_data,
  input  logic [ADDR_W-1:0]          chk_src1,
  input  logic [ADDR_W-1:0]          chk_src2,
  output logic                       hazard1,
  output logic                       hazard2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [ADDR_W-1:0] last_dst_q, last_dst_d;
  logic [DATA_W-1:0] last_data_q, last_data_d;
  logic [ADDR_W-1:0] mem_dst_q  [DEPTH];
  logic [ADDR_W-1:0] mem_dst_d  [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [DATA_W-1:0] mem_data_d [DEPTH];

  logic              accept_c;
  logic              wr1_acc;
  logic              wr2_acc;
  logic              drain;
  logic [PW-1:0]     tail_plus;
  logic [PW-1:0]     offset;

  always_comb begin
    // Admission looks only at the registered count; the drain in the same
    // cycle is deliberately ignored so accept has no path from the inputs.
    accept_c    = (count_q <= CW'(DEPTH - 2));
    wr1_acc     = wr1_valid & accept_c;
    wr2_acc     = wr2_valid & accept_c;
    drain       = (count_q != '0);

    mem_dst_d   = mem_dst_q;
    mem_data_d  = mem_data_q;
    // wr2 lands right after wr1 when both are taken, else at the tail itself.
    tail_plus   = tail_q + PW'(wr1_acc);
    if (wr1_acc) begin
      mem_dst_d[tail_q]  = wr1_dst;
      mem_data_d[tail_q] = wr1_data;
    end
    if (wr2_acc) begin
      mem_dst_d[tail_plus]  = wr2_dst;
      mem_data_d[tail_plus] = wr2_data;
    end

    tail_d      = tail_plus + PW'(wr2_acc);
    head_d      = head_q + PW'(drain);
    count_d     = count_q + CW'(wr1_acc) + CW'(wr2_acc) - CW'(drain);
    overflow_d  = overflow_q | (~accept_c & (wr1_valid | wr2_valid));

    // Remember the entry being drained so the write port holds it while empty.
    last_dst_d  = drain ? mem_dst_q[head_q]  : last_dst_q;
    last_data_d = drain ? mem_data_q[head_q] : last_data_q;

    hazard1 = 1'b0;
    hazard2 = 1'b0;
    offset  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      // Slot i is occupied when its distance from head is below count.
      offset = PW'(i) - head_q;
      if ({1'b0, offset} < count_q) begin
        if (mem_dst_q[i] == chk_src1) hazard1 = 1'b1;
        if (mem_dst_q[i] == chk_src2) hazard2 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      last_dst_q  <= '0;
      last_data_q <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      last_dst_q  <= last_dst_d;
      last_data_q <= last_data_d;
    end
  end

  // Entry storage needs no reset: only slots covered by count are ever read.
  always_ff @(posedge clk) begin
    mem_dst_q  <= mem_dst_d;
    mem_data_q <= mem_data_d;
  end

  assign accept   = accept_c;
  assign rf_we    = drain;
  assign rf_dst   = drain ? mem_dst_q[head_q]  : last_dst_q;
  assign rf_data  = drain ? mem_data_q[head_q] : last_data_q;
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign overflow = overflow_q;

endmodule
